// File: rtl/encoder_round_controller.sv
// Sequencing FSM for the 24-round encoder: loads input words, steps the external
// round counter through the rounds, then holds the result under a valid/ack handshake.
module encoder_round_controller #(
    parameter int LOAD_CYCLES = 4,
    parameter int LCW         = 3,
    parameter int ROUNDS      = 24,
    parameter int BCW         = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           cnt_co,
    input  logic           out_ack,
    output logic           ready,
    output logic           init0,
    output logic           enc,
    output logic           ld_en,
    output logic [LCW-1:0] ld_sel,
    output logic           round_en,
    output logic           first_rnd,
    output logic           out_valid,
    output logic [BCW-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);

    if (LOAD_CYCLES < 1 || ROUNDS < 1 || LOAD_CYCLES > (1 << LCW)) begin : g_param_check
        $error("encoder_round_controller: illegal LOAD_CYCLES/LCW/ROUNDS combination");
    end

    state_t         state;
    logic [LCW-1:0] loadCnt;
    logic           firstPending;

    // The round count itself lives in the external counter; this FSM only
    // waits for its carry-out, so ROUND ends on cnt_co rather than a local count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            loadCnt      <= '0;
            firstPending <= 1'b0;
            blk_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    loadCnt      <= '0;
                    firstPending <= 1'b0;
                    if (start && !abort) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state   <= IDLE;
                        loadCnt <= '0;
                    end else if (loadCnt == LOAD_LAST) begin
                        state        <= ROUND;
                        loadCnt      <= '0;
                        firstPending <= 1'b1;
                    end else begin
                        loadCnt <= loadCnt + LCW'(1);
                    end
                end
                ROUND: begin
                    firstPending <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt_co) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (out_ack) begin
                        state <= IDLE;
                        if (blk_cnt != '1) begin
                            blk_cnt <= blk_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    loadCnt      <= '0;
                    firstPending <= 1'b0;
                end
            endcase
        end
    end

    // Abort suppresses every datapath action in its cycle and clears the counter instead.
    always_comb begin
        ready     = 1'b0;
        init0     = 1'b0;
        enc       = 1'b0;
        ld_en     = 1'b0;
        round_en  = 1'b0;
        first_rnd = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                init0 = start && !abort;
            end
            LOAD: begin
                init0 = abort;
                ld_en = !abort;
            end
            ROUND: begin
                init0     = abort;
                enc       = !abort && !cnt_co;
                round_en  = !abort && !cnt_co;
                first_rnd = !abort && !cnt_co && firstPending;
            end
            DONE: begin
                init0     = abort;
                out_valid = !abort;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign ld_sel = loadCnt;

endmodule

// File: tb/tb_encoder_round_controller.sv
// Self-checking bench for encoder_round_controller: models the external round counter
// and checks every cycle against a start-relative timeline of expected outputs.
module tb_encoder_round_controller;

    localparam int L      = 4;
    localparam int LCW    = 3;
    localparam int ROUNDS = 24;
    localparam int BCW    = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic           abort;
    logic           cnt_co;
    logic           out_ack;
    logic           ready;
    logic           init0;
    logic           enc;
    logic           ld_en;
    logic [LCW-1:0] ld_sel;
    logic           round_en;
    logic           first_rnd;
    logic           out_valid;
    logic [BCW-1:0] blk_cnt;

    logic           coSpur;
    logic [4:0]     roundCnt;
    logic           roundCo;

    int checks;
    int fails;
    int expBlk;

    encoder_round_controller #(
        .LOAD_CYCLES(L),
        .LCW(LCW),
        .ROUNDS(ROUNDS),
        .BCW(BCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .cnt_co(cnt_co),
        .out_ack(out_ack),
        .ready(ready),
        .init0(init0),
        .enc(enc),
        .ld_en(ld_en),
        .ld_sel(ld_sel),
        .round_en(round_en),
        .first_rnd(first_rnd),
        .out_valid(out_valid),
        .blk_cnt(blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the external round counter.
    assign roundCo = (roundCnt == 5'(ROUNDS));
    assign cnt_co  = roundCo | coSpur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            roundCnt <= '0;
        end else if (init0 || roundCo) begin
            roundCnt <= '0;
        end else if (enc) begin
            roundCnt <= roundCnt + 5'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs k cycles after an accepted start.
    function automatic logic [26:0] expectedVec(input int k, input int spurCycle, input int blk);
        logic         eReady, eInit0, eLd, eRnd, eFirst, eValid, eCo;
        logic [2:0]   eSel;
        eReady = (k == 0);
        eInit0 = (k == 0);
        eLd    = (k >= 1) && (k <= L);
        eSel   = eLd ? 3'(k - 1) : 3'd0;
        eRnd   = (k >= L + 1) && (k <= L + ROUNDS);
        eFirst = (k == L + 1);
        eValid = (k >= L + ROUNDS + 2);
        eCo    = (k == L + ROUNDS + 1) || (k == spurCycle);
        return {eReady, eInit0, eRnd, eLd, eSel, eRnd, eFirst, eValid, eCo, 16'(blk)};
    endfunction

    function automatic logic [26:0] observedVec();
        return {ready, init0, enc, ld_en, ld_sel, round_en, first_rnd, out_valid, cnt_co, blk_cnt};
    endfunction

    task automatic test_reset();
        logic [26:0] exp;
        exp = {1'b1, 10'b0, 16'd0};
        checks++;
        if (observedVec() !== exp) begin
            fails++;
            $display("[TB] FAIL reset_state: got %h expected %h", observedVec(), exp);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (observedVec() !== exp) begin
            fails++;
            $display("[TB] FAIL post_reset_idle: got %h expected %h", observedVec(), exp);
        end
    endtask

    task automatic test_nominal(input int ackDelay, input int spurCycle, input int startCycle);
        int ackCycle;
        logic [26:0] exp;
        ackCycle = L + ROUNDS + 2 + ackDelay;
        for (int k = 0; k <= ackCycle; k++) begin
            start   = (k == 0) || (k == startCycle);
            coSpur  = (k == spurCycle);
            out_ack = (k == ackCycle);
            #1;
            exp = expectedVec(k, spurCycle, expBlk);
            checks++;
            if (observedVec() !== exp) begin
                fails++;
                $display("[TB] FAIL block_cycle_%0d: got %h expected %h", k, observedVec(), exp);
            end
            tick();
        end
        start   = 1'b0;
        coSpur  = 1'b0;
        out_ack = 1'b0;
        expBlk++;
        #1;
        checks++;
        if ({ready, out_valid, blk_cnt} !== {1'b1, 1'b0, 16'(expBlk)}) begin
            fails++;
            $display("[TB] FAIL after_ack: got ready=%b valid=%b blk=%0d expected ready=1 valid=0 blk=%0d",
                     ready, out_valid, blk_cnt, expBlk);
        end
    endtask

    task automatic test_abort(input int abortCycle);
        logic [26:0] exp;
        for (int k = 0; k < abortCycle; k++) begin
            start = (k == 0);
            #1;
            exp = expectedVec(k, -1, expBlk);
            checks++;
            if (observedVec() !== exp) begin
                fails++;
                $display("[TB] FAIL abort_lead_cycle_%0d: got %h expected %h", k, observedVec(), exp);
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b1;
        #1;
        checks++;
        if ({ready, init0, enc, round_en} !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL abort_cycle_%0d: got ready/init0/enc/round_en=%b expected 0100",
                     abortCycle, {ready, init0, enc, round_en});
        end
        tick();
        abort = 1'b0;
        #1;
        checks++;
        if ({ready, out_valid, ld_en, round_en, ld_sel, blk_cnt} !== {4'b1000, 3'd0, 16'(expBlk)}) begin
            fails++;
            $display("[TB] FAIL abort_recover: got ready=%b valid=%b ld=%b rnd=%b sel=%0d blk=%0d expected 1 0 0 0 0 %0d",
                     ready, out_valid, ld_en, round_en, ld_sel, blk_cnt, expBlk);
        end
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        #1;
        checks++;
        if ({ready, init0} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL abort_idle_cycle: got ready/init0=%b expected 10", {ready, init0});
        end
        tick();
        abort = 1'b0;
        #1;
        checks++;
        if ({ready, ld_en, out_valid} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL abort_idle_after: got ready/ld/valid=%b expected 100", {ready, ld_en, out_valid});
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            test_nominal(0, -1, -1);
        end
    endtask

    task automatic test_spurious();
        coSpur = 1'b1;
        #1;
        tick();
        coSpur = 1'b0;
        #1;
        checks++;
        if ({ready, ld_en, out_valid} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL spurious_co_idle: got ready/ld/valid=%b expected 100", {ready, ld_en, out_valid});
        end
        test_nominal(int'($urandom_range(2, 0)), int'($urandom_range(L, 1)),
                     int'($urandom_range(L + ROUNDS, L + 2)));
    endtask

    task automatic test_reset_midround();
        for (int k = 0; k <= L + 11; k++) begin
            start = (k == 0);
            #1;
            if (k < L + 11) begin
                tick();
            end
        end
        start = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, enc, round_en, out_valid, init0, blk_cnt} !== {5'b10000, 16'd0}) begin
            fails++;
            $display("[TB] FAIL reset_midround: got ready=%b enc=%b rnd=%b valid=%b init0=%b blk=%0d expected 1 0 0 0 0 0",
                     ready, enc, round_en, out_valid, init0, blk_cnt);
        end
        expBlk = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        expBlk  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        out_ack = 1'b0;
        coSpur  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        $display("[TB] nominal block");
        test_nominal(0, -1, -1);
        $display("[TB] delayed ack");
        test_nominal(7, -1, -1);
        test_abort_idle();
        $display("[TB] abort in ROUND at round 12");
        test_abort(L + 1 + 12);
        test_nominal(int'($urandom_range(3, 0)), -1, -1);
        test_abort(int'($urandom_range(L, 1)));
        test_abort(L + 1 + int'($urandom_range(ROUNDS - 1, 0)));
        test_abort(L + ROUNDS + 2 + int'($urandom_range(4, 0)));
        $display("[TB] back-to-back blocks");
        test_back_to_back();
        $display("[TB] spurious inputs");
        test_spurious();
        $display("[TB] reset mid-round");
        test_reset_midround();
        test_nominal(int'($urandom_range(3, 0)), -1, -1);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
